// File: rtl/i2s_dac_tx_if.sv
// Sample stream between an audio source and the I2S DAC transmitter.
// Latency: none, wires only.
// Backpressure: the source holds audio_valid/audio_data until it sees audio_ready high on a clk edge.
interface i2s_dac_tx_if #(
    parameter int N = 16
);
    logic [N-1:0] audio_data;
    logic         audio_valid;
    logic         audio_ready;

    modport master (output audio_data, output audio_valid, input audio_ready);
    modport slave  (input audio_data, input audio_valid, output audio_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// Serialises one N-bit sample per frame onto an I2S DAC line, duplicated on left and right slots.
// Latency: codec clock edges are acted on 3 clk after they occur; the MSB leaves one bclk after the slot starts.
// Backpressure: audio_ready is low while the one-entry holding register is full; each frame start frees it.
module i2s_dac_tx #(
    parameter int N = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    i2s_dac_tx_if.slave sink,
    input  logic        bclk,
    input  logic        daclrck,
    output logic        dacdat,
    output logic        underrun,
    output logic [7:0]  underrun_count
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2:0]     bclk_sync;
    logic [2:0]     lrck_sync;
    logic           bclk_fall;
    logic           lr_fall;
    logic           lr_rise;
    logic           right_start;
    logic           bit_tick;
    logic           take;
    logic           full;
    logic [N-1:0]   hold;
    logic [N-1:0]   shreg;
    logic [N-1:0]   last;
    logic [CW-1:0]  bit_cnt;

    // Two synchroniser stages plus a history stage for each codec clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], bclk};
            lrck_sync <= {lrck_sync[1:0], daclrck};
        end
    end

    assign bclk_fall   = bclk_sync[2] & ~bclk_sync[1];
    assign lr_fall     = lrck_sync[2] & ~lrck_sync[1];
    assign lr_rise     = ~lrck_sync[2] & lrck_sync[1];
    // Right slots only count once a left frame has been seen.
    assign right_start = lr_rise && (state != WAIT_SYNC);
    // A frame-clock edge wins over a coincident bit-clock edge.
    assign bit_tick    = bclk_fall && !lr_fall && !lr_rise && (state != WAIT_SYNC);

    assign sink.audio_ready = ~full;
    assign take             = sink.audio_valid & ~full;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: falling frame clock opens a left slot, rising opens the right slot.
    always_comb begin
        state_nxt = state;
        if (lr_fall) begin
            state_nxt = LEFT;
        end else if (right_start) begin
            state_nxt = RIGHT;
        end
    end

    // Holding register: a same-cycle accept and frame start leaves the new sample stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            hold <= '0;
        end else if (take) begin
            hold <= sink.audio_data;
            full <= 1'b1;
        end else if (lr_fall) begin
            full <= 1'b0;
        end
    end

    // Shift datapath, repeat-on-starvation and saturating underrun counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg          <= '0;
            last           <= '0;
            bit_cnt        <= '0;
            dacdat         <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            underrun <= 1'b0;
            if (lr_fall) begin
                bit_cnt <= CW'(N);
                dacdat  <= 1'b0;
                if (full) begin
                    shreg <= hold;
                    last  <= hold;
                end else begin
                    shreg    <= last;
                    underrun <= 1'b1;
                    if (underrun_count != 8'hFF) begin
                        underrun_count <= underrun_count + 8'd1;
                    end
                end
            end else if (right_start) begin
                shreg   <= last;
                bit_cnt <= CW'(N);
                dacdat  <= 1'b0;
            end else if (bit_tick) begin
                if (bit_cnt != '0) begin
                    dacdat  <= shreg[N-1];
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                end else begin
                    dacdat <= 1'b0;
                end
            end
        end
    end
endmodule
